ibex_fetch_req_engine: RTL

- Instruction-side bus initiator that fills the fetch FIFO.
- Issues word fetch requests on the OBI-style instr bus and tracks up to NUM_REQS outstanding transactions.
- Pushes in-order responses into the FIFO input port (valid/addr/rdata/err) and respects FIFO occupancy via busy.
- Handles branches by clearing the FIFO and discarding stale in-flight responses; sits between the instruction memory interface and ibex_fetch_fifo.

---
 rtl/ibex_pkg.sv | 6 +
 rtl/ibex_fetch_addr_queue.sv | 60 ++++++
 rtl/ibex_fetch_req_engine.sv | 110 +++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared widths and fetch request engine states
package ibex_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    typedef enum logic [1:0] {IDLE, REQ, BR_WAIT} fetch_req_state_e;
endpackage

// File: rtl/ibex_fetch_addr_queue.sv
// ibex_fetch_addr_queue: in-order {addr, discard} record per granted fetch
module ibex_fetch_addr_queue
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              push_discard_i,
    input  logic              pop_i,
    input  logic              mark_all_discard_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic              head_discard_o
);
    localparam int unsigned PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [PTR_W-1:0]  rptr_q, wptr_q;
    logic [NUM_REQS-1:0] disc_q;
    logic [ADDR_W-1:0] addr_q [NUM_REQS];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQS - 1)) ? '0 : p + 1'b1;
    endfunction

    // a push in the same cycle as mark_all wins for its own slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            disc_q <= '0;
        end else begin
            if (mark_all_discard_i) disc_q <= '1;
            if (push_i) begin
                disc_q[wptr_q] <= push_discard_i;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop_i) rptr_q <= ptr_inc(rptr_q);
        end
    end

    if (ResetAll) begin : g_addr_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k < NUM_REQS; k++) addr_q[k] <= '0;
            end else if (push_i) begin
                addr_q[wptr_q] <= push_addr_i;
            end
        end
    end else begin : g_addr_nrst
        always_ff @(posedge clk_i) begin
            if (push_i) addr_q[wptr_q] <= push_addr_i;
        end
    end

    assign head_addr_o    = addr_q[rptr_q];
    assign head_discard_o = disc_q[rptr_q];
endmodule

// File: rtl/ibex_fetch_req_engine.sv
// ibex_fetch_req_engine: instr bus initiator feeding the fetch FIFO
module ibex_fetch_req_engine
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic                busy_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [ADDR_W-1:0]   fifo_addr_o,
    output logic [DATA_W-1:0]   fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [ADDR_W-1:0]   instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [DATA_W-1:0]   instr_rdata_i,
    input  logic                instr_err_i
);
    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);

    fetch_req_state_e  state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d, next_addr_q, next_addr_d, tgt_addr, head_addr;
    logic [CNT_W-1:0]  out_q, cnt_next;
    logic [2**CNT_W-1:0] slot_busy;
    logic granted, rvalid_ok, issue_ok, launch, head_discard, unused_addr_lsb;

    assign granted   = instr_req_o & instr_gnt_i;
    assign rvalid_ok = instr_rvalid_i & (out_q != '0);
    assign cnt_next  = out_q + CNT_W'(granted) - CNT_W'(rvalid_ok);

    // slot_busy[n]: the FIFO cannot absorb n+1 words; counts beyond NUM_REQS are always busy
    always_comb begin
        slot_busy = '1;
        for (int k = 0; k < NUM_REQS; k++) slot_busy[k] = fifo_busy_i[NUM_REQS-1-k];
    end

    assign issue_ok = req_i & ~slot_busy[cnt_next];
    assign launch   = (state_q == IDLE) | granted;
    assign tgt_addr = branch_i ? {addr_i[ADDR_W-1:1], 1'b0} :
                      (state_q == REQ) ? {req_addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4) : next_addr_q;

    // next_addr_q holds the next fetch address while idle and the latched target in BR_WAIT
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        next_addr_d = next_addr_q;
        if (launch) begin
            state_d = issue_ok ? REQ : IDLE;
            if (issue_ok) req_addr_d = tgt_addr;
            else          next_addr_d = tgt_addr;
        end else if (branch_i) begin
            state_d     = BR_WAIT;
            next_addr_d = tgt_addr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            next_addr_q <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            next_addr_q <= next_addr_d;
            out_q       <= cnt_next;
        end
    end

    ibex_fetch_addr_queue #(
        .NUM_REQS (NUM_REQS),
        .ResetAll (ResetAll)
    ) u_addr_queue (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .push_i             (granted),
        .push_addr_i        (req_addr_q),
        .push_discard_i     (branch_i | (state_q == BR_WAIT)),
        .pop_i              (rvalid_ok),
        .mark_all_discard_i (branch_i),
        .head_addr_o        (head_addr),
        .head_discard_o     (head_discard)
    );

    assign instr_req_o     = (state_q != IDLE);
    assign instr_addr_o    = {req_addr_q[ADDR_W-1:2], 2'b00};
    assign busy_o          = instr_req_o | (out_q != '0);
    assign fifo_clear_o    = branch_i;
    assign fifo_valid_o    = rvalid_ok & ~head_discard & ~branch_i;
    assign fifo_addr_o     = head_addr;
    assign fifo_rdata_o    = instr_rdata_i;
    assign fifo_err_o      = instr_err_i;
    assign unused_addr_lsb = addr_i[0];

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> out_q != '0);
    a_max_out: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_q <= CNT_W'(NUM_REQS));
    a_bus_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_req_o && !instr_gnt_i |=> instr_req_o && $stable(instr_addr_o));
endmodule
